// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types for the register-file write-port arbiter.
//   ADDRESS_WIDTH_DEFAULT / DATA_WIDTH_DEFAULT : default register index / data widths
//   wb_req_t    : one buffered writeback request {addr, data} at the default widths
//   arb_state_e : arbiter priority state
package rf_arb_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEFAULT = 5;
  localparam int unsigned DATA_WIDTH_DEFAULT    = 32;

  typedef struct packed {
    logic [ADDRESS_WIDTH_DEFAULT-1:0] addr;
    logic [DATA_WIDTH_DEFAULT-1:0]    data;
  } wb_req_t;

  typedef enum logic [0:0] {
    GRANT_A,
    GRANT_B_FORCED
  } arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order buffer of writeback requests with address lookups.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   push_i / push_req_i    : enqueue a request (caller guarantees !full_o)
//   pop_i                  : dequeue the head (caller guarantees !empty_o)
//   full_o, empty_o, head_o: occupancy and oldest entry
//   m1/m2_addr_i, *_hit_o  : read-port lookups (address 0 never hits)
//   waw_addr_i, waw_hit_o  : lookup used for cross-requester WAW blocking
// Build option RF_ARB_BYPASS_EN adds m1_data_o / m2_data_o, the data of the youngest match.
module wb_fifo
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int unsigned DEPTH         = 2,
  parameter type         req_t         = wb_req_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  req_t                     push_req_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output req_t                     head_o,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr_i,
  input  logic [ADDRESS_WIDTH-1:0] m2_addr_i,
  input  logic [ADDRESS_WIDTH-1:0] waw_addr_i,
  output logic                     m1_hit_o,
  output logic                     m2_hit_o,
`ifdef RF_ARB_BYPASS_EN
  output logic [$bits(req_t)-ADDRESS_WIDTH-1:0] m1_data_o,
  output logic [$bits(req_t)-ADDRESS_WIDTH-1:0] m2_data_o,
`endif
  output logic                     waw_hit_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  idx;

  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    if (push_i) begin
      mem_d[wr_ptr_q]   = push_req_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Per-slot valid bits: the write slot still occupied means full, the read slot empty means empty.
  always_comb begin
    full_o  = valid_q[wr_ptr_q];
    empty_o = !valid_q[rd_ptr_q];
    head_o  = mem_q[rd_ptr_q];
  end

  always_comb begin
    m1_hit_o  = 1'b0;
    m2_hit_o  = 1'b0;
    waw_hit_o = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    m1_data_o = '0;
    m2_data_o = '0;
`endif
    idx = rd_ptr_q;
    // Walk oldest to youngest so the last hit seen is the youngest entry.
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = rd_ptr_q + PtrW'(k);
      if (valid_q[idx]) begin
        if (m1_addr_i != '0 && mem_q[idx].addr == m1_addr_i) begin
          m1_hit_o = 1'b1;
`ifdef RF_ARB_BYPASS_EN
          m1_data_o = mem_q[idx].data;
`endif
        end
        if (m2_addr_i != '0 && mem_q[idx].addr == m2_addr_i) begin
          m2_hit_o = 1'b1;
`ifdef RF_ARB_BYPASS_EN
          m2_data_o = mem_q[idx].data;
`endif
        end
        if (waw_addr_i != '0 && mem_q[idx].addr == waw_addr_i) begin
          waw_hit_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file write port between the ALU writeback (A) and the
// load / multi-cycle writeback (B). Each side is buffered; A has priority unless B has waited
// STARVE_LIMIT cycles. Pending-write hazard flags are returned to decode.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data   : requester A handshake (address 0 is accepted and dropped)
//   b_valid/b_ready/b_addr/b_data   : requester B handshake
//   we3/a3/wd3                      : register file write port (a3/wd3 are 0 when we3=0)
//   rd_addr1/rd_addr2, hazard1/2    : decode read addresses and pending-write flags
// Build option RF_ARB_BYPASS_EN adds fwd1_valid/fwd1_data and fwd2_valid/fwd2_data, carrying
// the youngest buffered data for each read address.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0]    wd3,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr1,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr2,
`ifdef RF_ARB_BYPASS_EN
  output logic                     fwd1_valid,
  output logic [DATA_WIDTH-1:0]    fwd1_data,
  output logic                     fwd2_valid,
  output logic [DATA_WIDTH-1:0]    fwd2_data,
`endif
  output logic                     hazard1,
  output logic                     hazard2
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } req_t;

  // One spare count value so STARVE_LIMIT itself always fits.
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

  req_t            a_req, b_req, a_head, b_head;
  logic            a_full, a_empty, b_full, b_empty;
  logic            a_push, b_push;
  logic            a_waw, b_waw;
  logic            a_m1_hit, a_m2_hit, b_m1_hit, b_m2_hit;
  logic            grant_a, grant_b;
  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`ifdef RF_ARB_BYPASS_EN
  logic [DATA_WIDTH-1:0] a_m1_data, a_m2_data, b_m1_data, b_m2_data;
`endif

  // A WAW hit against the other buffer holds the requester off until that entry drains, which
  // keeps same-register writes in order and makes at most one buffer match any address.
  always_comb begin
    a_req   = '{addr: a_addr, data: a_data};
    b_req   = '{addr: b_addr, data: b_data};
    a_ready = !a_full && !a_waw;
    b_ready = !b_full && !b_waw;
    a_push  = a_valid && a_ready && (a_addr != '0);
    b_push  = b_valid && b_ready && (b_addr != '0);
    hazard1 = a_m1_hit || b_m1_hit;
    hazard2 = a_m2_hit || b_m2_hit;
`ifdef RF_ARB_BYPASS_EN
    fwd1_valid = hazard1;
    fwd1_data  = a_m1_hit ? a_m1_data : b_m1_data;
    fwd2_valid = hazard2;
    fwd2_data  = a_m2_hit ? a_m2_data : b_m2_data;
`endif
  end

  wb_fifo #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH),
    .req_t         (req_t)
  ) u_a_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (a_push),
    .push_req_i (a_req),
    .pop_i      (grant_a),
    .full_o     (a_full),
    .empty_o    (a_empty),
    .head_o     (a_head),
    .m1_addr_i  (rd_addr1),
    .m2_addr_i  (rd_addr2),
    .waw_addr_i (b_addr),
    .m1_hit_o   (a_m1_hit),
    .m2_hit_o   (a_m2_hit),
`ifdef RF_ARB_BYPASS_EN
    .m1_data_o  (a_m1_data),
    .m2_data_o  (a_m2_data),
`endif
    .waw_hit_o  (b_waw)
  );

  wb_fifo #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH),
    .req_t         (req_t)
  ) u_b_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (b_push),
    .push_req_i (b_req),
    .pop_i      (grant_b),
    .full_o     (b_full),
    .empty_o    (b_empty),
    .head_o     (b_head),
    .m1_addr_i  (rd_addr1),
    .m2_addr_i  (rd_addr2),
    .waw_addr_i (a_addr),
    .m1_hit_o   (b_m1_hit),
    .m2_hit_o   (b_m2_hit),
`ifdef RF_ARB_BYPASS_EN
    .m1_data_o  (b_m1_data),
    .m2_data_o  (b_m2_data),
`endif
    .waw_hit_o  (a_waw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GRANT_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Starvation counter: counts cycles B waits while non-empty; B is forced once it saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (b_empty || grant_b) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(STARVE_LIMIT)) begin
      cnt_d = cnt_q + CntW'(1);
    end
    state_d = (cnt_d == CntW'(STARVE_LIMIT)) ? GRANT_B_FORCED : GRANT_A;
  end

  always_comb begin
    grant_b = !b_empty && (a_empty || state_q == GRANT_B_FORCED);
    grant_a = !a_empty && !grant_b;
    we3     = grant_a || grant_b;
    a3      = '0;
    wd3     = '0;
    if (grant_b) begin
      a3  = b_head.addr;
      wd3 = b_head.data;
    end else if (grant_a) begin
      a3  = a_head.addr;
      wd3 = a_head.data;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_addr, b_addr, a3, rd_addr1, rd_addr2;
  logic [DW-1:0] a_data, b_data, wd3;
  logic          we3, hazard1, hazard2;
`ifdef RF_ARB_BYPASS_EN
  logic          fwd1_valid, fwd2_valid;
  logic [DW-1:0] fwd1_data, fwd2_data;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned n_writes = 0;
  int unsigned base;
  logic [DW-1:0] rf_cap [32];

  rf_write_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (2),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .we3        (we3),
    .a3         (a3),
    .wd3        (wd3),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
`ifdef RF_ARB_BYPASS_EN
    .fwd1_valid (fwd1_valid),
    .fwd1_data  (fwd1_data),
    .fwd2_valid (fwd2_valid),
    .fwd2_data  (fwd2_data),
`endif
    .hazard1    (hazard1),
    .hazard2    (hazard2)
  );

  always #5 clk = ~clk;

  // Register file model: sample the write port 1ns before the rising edge that commits it.
  always @(negedge clk) begin
    #4;
    if (we3 === 1'b1) begin
      n_writes++;
      rf_cap[a3] = wd3;
    end
  end

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    rd_addr1 = '0; rd_addr2 = '0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %0h want 0", we3); end
    n_cmp++; if (a3 !== '0) begin n_fail++; $display("FAIL reset_a3: got %0h want 0", a3); end
    n_cmp++; if (wd3 !== '0) begin n_fail++; $display("FAIL reset_wd3: got %0h want 0", wd3); end
    n_cmp++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_hazard: got %0h%0h want 00", hazard1, hazard2);
    end
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: got %0h want 1", a_ready); end
    n_cmp++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready: got %0h want 1", b_ready); end
  endtask

  task automatic test_single_a();
    @(negedge clk);
    base = n_writes;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0h want 1", a_ready); end
    n_cmp++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL single_hz_pre: got %0h want 0", hazard1); end
    @(negedge clk);
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    #1;
    n_cmp++; if (we3 !== 1'b1) begin n_fail++; $display("FAIL single_we3: got %0h want 1", we3); end
    n_cmp++; if (a3 !== 5'd5) begin n_fail++; $display("FAIL single_a3: got %0d want 5", a3); end
    n_cmp++; if (wd3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wd3: got %0h want deadbeef", wd3); end
    n_cmp++; if (hazard1 !== 1'b1) begin n_fail++; $display("FAIL single_hz_pend: got %0h want 1", hazard1); end
    @(negedge clk);
    #1;
    n_cmp++; if (we3 !== 1'b0 || a3 !== '0 || wd3 !== '0) begin
      n_fail++; $display("FAIL single_idle: got we3=%0h a3=%0d wd3=%0h want 0/0/0", we3, a3, wd3);
    end
    n_cmp++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL single_hz_post: got %0h want 0", hazard1); end
    n_cmp++; if (rf_cap[5] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_rf5: got %0h want deadbeef", rf_cap[5]);
    end
    n_cmp++; if (n_writes - base !== 1) begin n_fail++; $display("FAIL single_nwr: got %0d want 1", n_writes - base); end
    idle_inputs();
  endtask

  task automatic test_addr_zero();
    @(negedge clk);
    base = n_writes;
    a_valid = 1'b1; a_addr = '0; a_data = 32'h1234; rd_addr1 = '0;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %0h want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0; a_data = '0;
    #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL zero_we3: got %0h want 0", we3); end
    n_cmp++; if (hazard1 !== 1'b0) begin n_fail++; $display("FAIL zero_hz: got %0h want 0", hazard1); end
    @(negedge clk);
    #1;
    n_cmp++; if (n_writes - base !== 0) begin n_fail++; $display("FAIL zero_nwr: got %0d want 0", n_writes - base); end
    idle_inputs();
  endtask

  // Both requesters valid every cycle with distinct addresses; per-cycle write address and
  // ready expectations worked out by hand for STARVE_LIMIT=4, DEPTH=2.
  task automatic test_starvation();
    int exp_a3 [16];
    bit exp_ar [16];
    bit exp_br [16];
    int ai, bi;
    exp_a3 = '{0, 1, 2, 3, 4, 16, 5, 6, 7, 8, 17, 9, 10, 11, 12, 18};
    exp_ar = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    exp_br = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    ai = 0; bi = 0;
    @(negedge clk);
    base = n_writes;
    for (int c = 0; c < 16; c++) begin
      a_valid = 1'b1; a_addr = AW'(1 + ai);  a_data = 32'hA000_0000 + ai;
      b_valid = 1'b1; b_addr = AW'(16 + bi); b_data = 32'hB000_0000 + bi;
      #1;
      n_cmp++; if (we3 !== (exp_a3[c] != 0)) begin
        n_fail++; $display("FAIL starve_we3[%0d]: got %0h want %0h", c, we3, exp_a3[c] != 0);
      end
      n_cmp++; if (a3 !== AW'(exp_a3[c])) begin
        n_fail++; $display("FAIL starve_a3[%0d]: got %0d want %0d", c, a3, exp_a3[c]);
      end
      n_cmp++; if (a_ready !== exp_ar[c]) begin
        n_fail++; $display("FAIL starve_a_ready[%0d]: got %0h want %0h", c, a_ready, exp_ar[c]);
      end
      n_cmp++; if (b_ready !== exp_br[c]) begin
        n_fail++; $display("FAIL starve_b_ready[%0d]: got %0h want %0h", c, b_ready, exp_br[c]);
      end
      if (a_ready === 1'b1) ai++;
      if (b_ready === 1'b1) bi++;
      @(negedge clk);
    end
    idle_inputs();
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL starve_drained: got %0h want 0", we3); end
    n_cmp++; if (n_writes - base !== 18) begin
      n_fail++; $display("FAIL starve_nwr: got %0d want 18", n_writes - base);
    end
    for (int k = 0; k < 14; k++) begin
      n_cmp++; if (rf_cap[1 + k] !== 32'hA000_0000 + k) begin
        n_fail++; $display("FAIL starve_rfA[%0d]: got %0h want %0h", 1 + k, rf_cap[1 + k], 32'hA000_0000 + k);
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rf_cap[16 + k] !== 32'hB000_0000 + k) begin
        n_fail++; $display("FAIL starve_rfB[%0d]: got %0h want %0h", 16 + k, rf_cap[16 + k], 32'hB000_0000 + k);
      end
    end
  endtask

  task automatic test_waw();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hC0DE0003;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB7B7B7B7;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL waw_c1_ready: got %0h%0h want 11", a_ready, b_ready);
    end
    @(negedge clk);
    a_addr = 5'd7; a_data = 32'hA7A7A7A7;
    b_valid = 1'b0; b_addr = 5'd3; b_data = '0; rd_addr2 = 5'd7;
    #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL waw_c2_a_ready: got %0h want 0", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL waw_c2_b_ready: got %0h want 0", b_ready); end
    n_cmp++; if (a3 !== 5'd3) begin n_fail++; $display("FAIL waw_c2_a3: got %0d want 3", a3); end
    n_cmp++; if (hazard2 !== 1'b1) begin n_fail++; $display("FAIL waw_c2_hz2: got %0h want 1", hazard2); end
`ifdef RF_ARB_BYPASS_EN
    n_cmp++; if (fwd2_valid !== 1'b1 || fwd2_data !== 32'hB7B7B7B7) begin
      n_fail++; $display("FAIL waw_fwd2: got %0h/%0h want 1/b7b7b7b7", fwd2_valid, fwd2_data);
    end
`endif
    @(negedge clk);
    #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL waw_c3_a_ready: got %0h want 0", a_ready); end
    n_cmp++; if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'hB7B7B7B7) begin
      n_fail++; $display("FAIL waw_c3_write: got %0h/%0d/%0h want 1/7/b7b7b7b7", we3, a3, wd3);
    end
    n_cmp++; if (hazard2 !== 1'b1) begin n_fail++; $display("FAIL waw_c3_hz2: got %0h want 1", hazard2); end
    @(negedge clk);
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL waw_c4_a_ready: got %0h want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    n_cmp++; if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'hA7A7A7A7) begin
      n_fail++; $display("FAIL waw_c5_write: got %0h/%0d/%0h want 1/7/a7a7a7a7", we3, a3, wd3);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (rf_cap[7] !== 32'hA7A7A7A7) begin
      n_fail++; $display("FAIL waw_rf7: got %0h want a7a7a7a7", rf_cap[7]);
    end
    n_cmp++; if (hazard2 !== 1'b0) begin n_fail++; $display("FAIL waw_hz2_clear: got %0h want 0", hazard2); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h99;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h1010;
    @(negedge clk);
    a_addr = 5'd11; a_data = 32'h1111; b_valid = 1'b0;
    #1;
    n_cmp++; if (we3 !== 1'b1 || a3 !== 5'd9) begin
      n_fail++; $display("FAIL rmid_c2: got %0h/%0d want 1/9", we3, a3);
    end
    @(negedge clk);
    a_valid = 1'b0; rd_addr1 = 5'd11; rd_addr2 = 5'd10;
    #1;
    base = n_writes;
    n_cmp++; if (we3 !== 1'b1 || a3 !== 5'd11 || hazard1 !== 1'b1 || hazard2 !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got %0h/%0d/%0h%0h want 1/11/11", we3, a3, hazard1, hazard2);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (we3 !== 1'b0 || a3 !== '0 || wd3 !== '0) begin
      n_fail++; $display("FAIL rmid_we3: got %0h/%0d/%0h want 0/0/0", we3, a3, wd3);
    end
    n_cmp++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_hz: got %0h%0h want 00", hazard1, hazard2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_addr = 5'd10; b_addr = 5'd11;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_ready: got %0h%0h want 11", a_ready, b_ready);
    end
    n_cmp++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_hz_rel: got %0h%0h want 00", hazard1, hazard2);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (n_writes - base !== 0) begin
      n_fail++; $display("FAIL rmid_nwr: got %0d want 0", n_writes - base);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_a();
    test_addr_zero();
    test_starvation();
    test_waw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (we3/a3/wd3) between two writeback requesters.
- Requester A is the ALU writeback; requester B is the load/multi-cycle-unit writeback.
- Each requester has a small in-order buffer with a valid/ready handshake. A fixed-priority arbiter with starvation guard drains one write per cycle.
- Pending-write hazard flags go back to decode so it can stall on reads of not-yet-written registers.

Parameters:
- ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers)
- DATA_WIDTH, 32, register data width
- DEPTH, 2, entries per requester buffer (power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive cycles B may wait with non-empty buffer before forced grant

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  A write request
- a_ready  out  1  A buffer can accept
- a_addr  in  ADDRESS_WIDTH  A destination register
- a_data  in  DATA_WIDTH  A write data
- b_valid, b_ready, b_addr, b_data: same as A, for requester B
- we3  out  1  register file write enable
- a3  out  ADDRESS_WIDTH  register file write address
- wd3  out  DATA_WIDTH  register file write data
- rd_addr1, rd_addr2  in  ADDRESS_WIDTH  decode-stage read addresses
- hazard1, hazard2  out  1  pending write to rd_addr1 / rd_addr2 is buffered

Behaviour:
- Reset (async assert, sync release):
  - Both buffers empty; starvation counter = 0.
  - Outputs: we3=0, a3=0, wd3=0, hazard1=hazard2=0, a_ready=b_ready=1.
- Accept:
  - Transfer on rising clk when x_valid & x_ready.
  - x_ready = !full & !waw_block. It is based only on current state: no accept on a full buffer even if that buffer pops the same cycle.
- Address 0:
  - An accepted request with x_addr==0 completes the handshake but is discarded (never enqueued, never written).
- Cross-requester WAW:
  - a_ready=0 while a_addr matches any valid B entry (non-zero address).
  - b_ready=0 while b_addr matches any valid A entry.
  - The block clears once the matching entry drains.
  - Within one requester, order is FIFO.
- Issue:
  - we3/a3/wd3 are driven combinationally from the granted buffer head; at most one write per cycle.
  - The head is popped at the edge where we3=1.
  - Latency: accepted at edge N → we3=1 during cycle N+1 (if granted) → register written at edge N+2.
  - When we3=0, a3 and wd3 hold 0.
- Arbitration states: GRANT_A (default priority) and GRANT_B_FORCED.
  - A granted if A is non-empty, unless the starvation counter == STARVE_LIMIT.
  - B granted if A is empty, or the counter == STARVE_LIMIT.
- Starvation counter:
  - Increments each cycle B is non-empty and not granted; saturates at STARVE_LIMIT.
  - Clears when B is granted or B is empty.
- Hazard:
  - hazardN = rd_addrN != 0 and it matches the address of any valid entry in either buffer.
  - Combinational from registered state.
  - An entry being popped this cycle still flags its hazard (register not yet written).
- Simultaneous push/pop on a non-full buffer: both take effect; count unchanged.
- Reset mid-operation: buffered writes are lost; no write is issued during reset.

Optional Feature:
- Macro RF_ARB_BYPASS_EN.
- With it, adds outputs fwd1_valid/fwd1_data and fwd2_valid/fwd2_data:
  - valid when hazardN is set.
  - data is the youngest buffered entry matching rd_addrN. Cross-requester WAW blocking guarantees only one buffer can match.
  - Decode uses the forwarded data instead of stalling.
- Without it, those ports are absent and only the hazard flags exist.

Decomposition:
- Package rf_arb_pkg:
  - wb_req_t struct {addr, data}
  - ADDRESS_WIDTH/DATA_WIDTH defaults
  - arbiter state enum {GRANT_A, GRANT_B_FORCED}
- Sub-module wb_fifo, instantiated twice:
  - DEPTH-entry FIFO of wb_req_t with push/pop/full/empty.
  - Two CAM match ports returning hit plus youngest-match data.
  - Third match port for WAW checking.

Test Plan:
- Reset then A writes (addr 5, data 0xDEADBEEF) → a_ready=1; next cycle we3=1, a3=5, wd3=0xDEADBEEF; hazard1=1 while rd_addr1=5, then 0 after the pop edge.
- A and B both valid every cycle with distinct addresses, STARVE_LIMIT=4 → B is granted exactly once per 5 cycles while A stays non-empty; no write is lost.
- A fills DEPTH=2 entries with no drain opportunity → a_ready=0 on the cycle after the second accept; a third request is held until a pop.
- B holds pending addr 7, A presents addr 7 → a_ready=0 until B's entry writes; then A accepted; final register 7 value = A's data.
- a_addr=0, data 0x1234 → handshake completes; we3 never asserts for it; hazard1=0 for rd_addr1=0.
- rst_n asserted low mid-cycle with both buffers non-empty → we3=0 immediately; a_ready=b_ready=1 after release; hazards clear.
